avm_sram_bridge: RTL and testbench

- Parametrised Avalon-MM slave to asynchronous SRAM controller (IS61LV25616-class, 16-bit, UB/LB lanes). Successor to the fixed single-cycle SRAM controller.
- Adds `avm_waitrequest` and `avm_readdatavalid` handshaking, configurable read/write cycle counts for slower clocks or SRAMs, and Avalon data widths of 1, 2 or 4 SRAM words, serialised into multiple SRAM beats.
- Sits between the system interconnect and the top-level SRAM pad logic; the bidirectional data bus is resolved at top level.

---
 rtl/avm_sram_bridge.sv | 192 +++++++++++++++++++
 tb/tb_avm_sram_bridge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_sram_bridge.sv
// rtl/avm_sram_bridge.sv - Avalon-MM slave to async 16-bit SRAM bridge
// Serialises RATIO SRAM beats per Avalon word with programmable beat lengths.
module avm_sram_bridge #(
    parameter  int SRAM_AW   = 18,
    parameter  int RATIO     = 2,
    parameter  int RD_CYCLES = 1,
    parameter  int WR_CYCLES = 1,
    localparam int LOG2R     = $clog2(RATIO),
    localparam int AVM_DW    = 16 * RATIO,
    localparam int BE_W      = 2 * RATIO,
    localparam int AVM_AW    = SRAM_AW - LOG2R
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AVM_AW-1:0]   avm_address,
    input  logic [BE_W-1:0]     avm_byteenable,
    input  logic                avm_read,
    input  logic                avm_write,
    input  logic [AVM_DW-1:0]   avm_writedata,
    output logic [AVM_DW-1:0]   avm_readdata,
    output logic                avm_readdatavalid,
    output logic                avm_waitrequest,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [15:0]         sram_writedata,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n,
    input  logic [15:0]         sram_readdata
);

    localparam int BW   = (LOG2R > 0) ? LOG2R : 1;
    localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t              r_state, w_state_nx;
    logic [BW-1:0]       r_beat, w_beat_nx;
    logic [CW-1:0]       r_cyc, w_cyc_nx;
    logic [AVM_AW-1:0]   r_addr;
    logic [BE_W-1:0]     r_be;
    logic [AVM_DW-1:0]   r_wd, r_rbuf, r_rdata, w_rbuf_nx;
    logic                r_rvalid, w_rvalid_nx;
    logic [SRAM_AW-1:0]  r_sram_addr, w_sram_addr_nx;
    logic [15:0]         r_sram_wd, w_sram_wd_nx;
    logic                r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic                w_ce_n_nx, w_oe_n_nx, w_we_n_nx, w_ub_n_nx, w_lb_n_nx;
    logic                w_accept, w_drive, w_drv_wr, w_sample, w_last_cyc, w_last_beat, w_hold;
    logic [AVM_AW-1:0]   w_src_addr;
    logic [BE_W-1:0]     w_src_be;
    logic [AVM_DW-1:0]   w_src_wd;
    logic [1:0]          w_lanes;

    // Next beat/cycle are computed first; the strobes are then registered for that slot.
    always_comb begin
        w_state_nx  = r_state;
        w_beat_nx   = r_beat;
        w_cyc_nx    = r_cyc;
        w_accept    = 1'b0;
        w_drive     = 1'b0;
        w_drv_wr    = 1'b0;
        w_sample    = 1'b0;
        w_rvalid_nx = 1'b0;
        w_last_cyc  = (r_state == S_WR) ? (r_cyc == CW'(WR_CYCLES - 1))
                                        : (r_cyc == CW'(RD_CYCLES - 1));
        w_last_beat = (r_beat == BW'(RATIO - 1));
        case (r_state)
            S_IDLE: begin
                if (avm_write || avm_read) begin
                    w_accept   = 1'b1;
                    w_drive    = 1'b1;
                    w_drv_wr   = avm_write;
                    w_state_nx = avm_write ? S_WR : S_RD;
                    w_beat_nx  = '0;
                    w_cyc_nx   = '0;
                end
            end
            default: begin
                w_drv_wr = (r_state == S_WR);
                w_sample = (r_state == S_RD) && w_last_cyc;
                if (!w_last_cyc) begin
                    w_drive  = 1'b1;
                    w_cyc_nx = r_cyc + 1'b1;
                end else if (!w_last_beat) begin
                    w_drive   = 1'b1;
                    w_beat_nx = r_beat + 1'b1;
                    w_cyc_nx  = '0;
                end else begin
                    w_state_nx  = S_IDLE;
                    w_rvalid_nx = (r_state == S_RD);
                end
            end
        endcase
    end

    always_comb begin
        w_src_addr     = (r_state == S_IDLE) ? avm_address    : r_addr;
        w_src_be       = (r_state == S_IDLE) ? avm_byteenable : r_be;
        w_src_wd       = (r_state == S_IDLE) ? avm_writedata  : r_wd;
        w_lanes        = w_src_be[2*w_beat_nx +: 2];
        // The last cycle of a multi-cycle write beat releases we_n for data hold.
        w_hold         = (WR_CYCLES >= 2) && (w_cyc_nx == CW'(WR_CYCLES - 1));
        w_sram_addr_nx = r_sram_addr;
        w_sram_wd_nx   = r_sram_wd;
        w_ce_n_nx      = 1'b1;
        w_oe_n_nx      = 1'b1;
        w_we_n_nx      = 1'b1;
        w_ub_n_nx      = 1'b1;
        w_lb_n_nx      = 1'b1;
        if (w_drive) begin
            w_sram_addr_nx = (SRAM_AW'(w_src_addr) << LOG2R) | SRAM_AW'(w_beat_nx);
            if (w_drv_wr) begin
                w_sram_wd_nx = w_src_wd[16*w_beat_nx +: 16];
                w_ce_n_nx    = ~|w_lanes;
                w_we_n_nx    = ~|w_lanes | w_hold;
                w_ub_n_nx    = ~w_lanes[1];
                w_lb_n_nx    = ~w_lanes[0];
            end else begin
                w_ce_n_nx = 1'b0;
                w_oe_n_nx = 1'b0;
                w_ub_n_nx = 1'b0;
                w_lb_n_nx = 1'b0;
            end
        end
        w_rbuf_nx = r_rbuf;
        if (w_sample) begin
            w_rbuf_nx[16*r_beat +: 16] = sram_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_beat  <= w_beat_nx;
            r_cyc   <= w_cyc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_be        <= '0;
            r_wd        <= '0;
            r_rbuf      <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_sram_addr <= '0;
            r_sram_wd   <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
        end else begin
            if (w_accept) begin
                r_addr <= avm_address;
                r_be   <= avm_byteenable;
                r_wd   <= avm_writedata;
            end
            r_rbuf <= w_rbuf_nx;
            if (w_rvalid_nx) begin
                r_rdata <= w_rbuf_nx;
            end
            r_rvalid    <= w_rvalid_nx;
            r_sram_addr <= w_sram_addr_nx;
            r_sram_wd   <= w_sram_wd_nx;
            r_ce_n      <= w_ce_n_nx;
            r_oe_n      <= w_oe_n_nx;
            r_we_n      <= w_we_n_nx;
            r_ub_n      <= w_ub_n_nx;
            r_lb_n      <= w_lb_n_nx;
        end
    end

    assign avm_waitrequest   = reset | (r_state != S_IDLE);
    assign avm_readdata      = r_rdata;
    assign avm_readdatavalid = r_rvalid;
    assign sram_addr         = r_sram_addr;
    assign sram_writedata    = r_sram_wd;
    assign sram_ce_n         = r_ce_n;
    assign sram_oe_n         = r_oe_n;
    assign sram_we_n         = r_we_n;
    assign sram_ub_n         = r_ub_n;
    assign sram_lb_n         = r_lb_n;

endmodule

// File: tb/tb_avm_sram_bridge.sv
// tb/tb_avm_sram_bridge.sv - bench for avm_sram_bridge with two parameter sets
// Instance a: RATIO=2, RD=WR=1. Instance b: RATIO=2, RD_CYCLES=3, WR_CYCLES=2.
module tb_avm_sram_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [16:0] addr_a, addr_b;
    logic [3:0]  be_a, be_b;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] wd_a, wd_b, rdata_a, rdata_b;
    logic        rv_a, rv_b, wait_a, wait_b;
    logic [17:0] saddr_a, saddr_b;
    logic [15:0] swd_a, swd_b, srd_a, srd_b;
    logic        ce_a, oe_a, we_a, ub_a, lb_a;
    logic        ce_b, oe_b, we_b, ub_b, lb_b;

    avm_sram_bridge #(.SRAM_AW(18), .RATIO(2), .RD_CYCLES(1), .WR_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset), .avm_address(addr_a), .avm_byteenable(be_a),
        .avm_read(rd_a), .avm_write(wr_a), .avm_writedata(wd_a),
        .avm_readdata(rdata_a), .avm_readdatavalid(rv_a), .avm_waitrequest(wait_a),
        .sram_addr(saddr_a), .sram_writedata(swd_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a),
        .sram_we_n(we_a), .sram_ub_n(ub_a), .sram_lb_n(lb_a), .sram_readdata(srd_a));

    avm_sram_bridge #(.SRAM_AW(18), .RATIO(2), .RD_CYCLES(3), .WR_CYCLES(2)) u_dut_b (
        .clk(clk), .reset(reset), .avm_address(addr_b), .avm_byteenable(be_b),
        .avm_read(rd_b), .avm_write(wr_b), .avm_writedata(wd_b),
        .avm_readdata(rdata_b), .avm_readdatavalid(rv_b), .avm_waitrequest(wait_b),
        .sram_addr(saddr_b), .sram_writedata(swd_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b),
        .sram_we_n(we_b), .sram_ub_n(ub_b), .sram_lb_n(lb_b), .sram_readdata(srd_b));

    // Behavioural SRAMs: lane writes on the edge, read data settled mid-cycle.
    bit [15:0] mem_a [0:262143];
    bit [15:0] mem_b [0:262143];

    always @(posedge clk) begin
        if (!ce_a && !we_a) begin
            if (!ub_a) mem_a[saddr_a][15:8] <= swd_a[15:8];
            if (!lb_a) mem_a[saddr_a][7:0]  <= swd_a[7:0];
        end
        if (!ce_b && !we_b) begin
            if (!ub_b) mem_b[saddr_b][15:8] <= swd_b[15:8];
            if (!lb_b) mem_b[saddr_b][7:0]  <= swd_b[7:0];
        end
    end

    always @(negedge clk) begin
        srd_a <= (!ce_a && !oe_a) ? mem_a[saddr_a] : 16'hBAAD;
        srd_b <= (!ce_b && !oe_b) ? mem_b[saddr_b] : 16'hBAAD;
    end

    int n_checks = 0;
    int n_errors = 0;
    int rv_b_cnt = 0;
    logic [31:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rv_a) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rvalid_a_unexpected: got readdata %h, required no response", rdata_a);
            end else begin
                chk("sb_rdata_a", rdata_a, sb.pop_front());
            end
        end
        if (rv_b) rv_b_cnt++;
    end

    // Holds the command until accepted; returns just after the accepting edge.
    task automatic issue_a(input logic r, input logic w, input logic [16:0] a,
                           input logic [3:0] be, input logic [31:0] d,
                           input logic push, input logic [31:0] exp);
        int n;
        @(negedge clk);
        rd_a = r; wr_a = w; addr_a = a; be_a = be; wd_a = d;
        n = 0;
        while (wait_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout_a: waitrequest still 1 after %0d cycles, required 0", n);
        end else if (push) begin
            sb.push_back(exp);
        end
        @(posedge clk);
        #1;
        rd_a = 1'b0; wr_a = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 17'h00000, 4'hF,    32'h11112222, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 17'h00001, 4'hF,    32'h33334444, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 17'h1FFFF, 4'hF,    32'hCAFEF00D, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 17'h00001, 4'b0011, 32'hAAAA5555, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 17'h00000, 4'b0110, 32'h99887766, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 17'h00002, 4'b0000, 32'hFFFFFFFF, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 17'h00000, 4'hF,    32'h0,        32'h11887722};
        vecs[7]  = '{1'b1, 1'b0, 17'h00001, 4'hF,    32'h0,        32'h33335555};
        vecs[8]  = '{1'b1, 1'b0, 17'h1FFFF, 4'hF,    32'h0,        32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b0, 17'h00002, 4'hF,    32'h0,        32'h00000000};
        vecs[10] = '{1'b1, 1'b0, 17'h00100, 4'hF,    32'h0,        32'h1234BEEF};
        vecs[11] = '{1'b1, 1'b1, 17'h00055, 4'hF,    32'hA5A5A5A5, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 17'h00055, 4'hF,    32'h0,        32'hA5A5A5A5};

        reset = 1'b1;
        rd_a = 0; wr_a = 0; addr_a = 0; be_a = 0; wd_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; be_b = 0; wd_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_a", wait_a, 1);
        chk("rst_strb_a", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b11111);
        chk("rst_addr_a", saddr_a, 0);
        chk("rst_wdata_a", swd_a, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rvalid_a", rv_a, 0);
        chk("rst_wait_b", wait_b, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wait_a", wait_a, 0);

        // Full-width write, cycle by cycle.
        issue_a(0, 1, 17'h100, 4'hF, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        chk("w1_addr", saddr_a, 18'h200);
        chk("w1_data", swd_a, 16'hBEEF);
        chk("w1_strb", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b01000);
        chk("w1_wait", wait_a, 1);
        @(negedge clk);
        chk("w2_addr", saddr_a, 18'h201);
        chk("w2_data", swd_a, 16'hDEAD);
        chk("w2_strb", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b01000);
        @(negedge clk);
        chk("w3_strb", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b11111);
        chk("w3_wait", wait_a, 0);
        chk("w3_addr_hold", saddr_a, 18'h201);
        chk("w3_data_hold", swd_a, 16'hDEAD);

        // Read back with latency check.
        issue_a(1, 0, 17'h100, 4'hF, 0, 1, 32'hDEADBEEF);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                chk("r_strb", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b00100);
                chk("r_addr", saddr_a, (k == 1) ? 18'h200 : 18'h201);
                chk("r_rvalid_early", rv_a, 0);
                chk("r_wait", wait_a, 1);
            end else begin
                chk("r_rvalid", rv_a, 1);
                chk("r_rdata", rdata_a, 32'hDEADBEEF);
                chk("r_wait_done", wait_a, 0);
            end
        end

        // Upper lanes only: beat 0 idles, beat 1 writes.
        issue_a(0, 1, 17'h100, 4'b1100, 32'h12345678, 0, 0);
        @(negedge clk);
        chk("pw1_ce_we", {ce_a, we_a}, 2'b11);
        @(negedge clk);
        chk("pw2_strb", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b01000);
        chk("pw2_data", swd_a, 16'h1234);
        chk("pw2_addr", saddr_a, 18'h201);

        // Slow instance: two-cycle write beats with hold, three-cycle read beats.
        @(negedge clk);
        wr_b = 1; addr_b = 17'h010; be_b = 4'hF; wd_b = 32'h0BADF00D;
        chk("b_w_accept_wait", wait_b, 0);
        @(posedge clk);
        #1 wr_b = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                chk("b_w_addr", saddr_b, (k <= 2) ? 18'h020 : 18'h021);
                chk("b_w_data", swd_b, (k <= 2) ? 16'hF00D : 16'h0BAD);
                chk("b_w_strb", {ce_b, oe_b, we_b, ub_b, lb_b}, {2'b01, (k % 2 == 0), 2'b00});
                chk("b_w_wait", wait_b, 1);
            end else begin
                chk("b_w_idle_strb", {ce_b, oe_b, we_b, ub_b, lb_b}, 5'b11111);
                chk("b_w_idle_wait", wait_b, 0);
            end
        end
        rd_b = 1;
        @(posedge clk);
        #1 rd_b = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k <= 6) begin
                chk("b_r_strb", {ce_b, oe_b, we_b, ub_b, lb_b}, 5'b00100);
                chk("b_r_addr", saddr_b, (k <= 3) ? 18'h020 : 18'h021);
                chk("b_r_wait", wait_b, 1);
                chk("b_r_rvalid_early", rv_b, 0);
            end else if (k == 7) begin
                chk("b_r_rvalid", rv_b, 1);
                chk("b_r_rdata", rdata_b, 32'h0BADF00D);
                chk("b_r_wait_done", wait_b, 0);
            end else begin
                chk("b_r_rvalid_pulse", rv_b, 0);
                chk("b_r_rdata_hold", rdata_b, 32'h0BADF00D);
            end
        end

        // Back-to-back command table through the scoreboard.
        for (int i = 0; i < 13; i++) begin
            issue_a(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
                    vecs[i].rd && !vecs[i].wr, vecs[i].exp);
        end
        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("table_drain", sb.size(), 0);

        // Reset in the second cycle of a read discards it.
        issue_a(1, 0, 17'h100, 4'hF, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_wait", wait_a, 1);
        @(negedge clk);
        chk("mid_rst_strb", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b11111);
        chk("mid_rst_rvalid", rv_a, 0);
        chk("mid_rst_wait2", wait_a, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_release_wait", wait_a, 0);
        chk("mid_rst_release_rvalid", rv_a, 0);
        issue_a(1, 0, 17'h100, 4'hF, 0, 1, 32'h1234BEEF);
        begin
            int n = 0;
            while (sb.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("final_drain", sb.size(), 0);
        repeat (4) @(negedge clk);
        chk("rv_b_count", rv_b_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
